r2b_core_dispatch: RTL and testbench
====================================

Name: r2b_core_dispatch

Overview:
- Sits directly downstream of the horizontal row-to-block converter (r2b_converter_h) in the Multi-MAC matrix-multiply path.
- Captures each block beat the converter emits and splits it into NUM_CORES_H per-core lanes of CHUNK_SIZE words each.
- Presents the lanes to the MAC cores over independent valid/ready handshakes.
- The converter has no backpressure, so this block buffers beats in a small FIFO and flags any loss.

Parameters:
- WIDTH, 16, bits per element (fixed-point word).
- FRAC_WIDTH, 8, fractional bits; pass-through only, no arithmetic is done on data.
- CHUNK_SIZE, 4, words per core lane per beat (BLOCK_SIZE*BLOCK_SIZE).
- NUM_CORES_H, 3, number of core lanes.
- DEPTH, 4, FIFO entries; must be >= 2 and need not be a power of two.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable.
- in_valid  in  1  beat strobe; driven by converter output_ready.
- in_data  in  WIDTH*CHUNK_SIZE*NUM_CORES_H  beat payload; driven by converter out_data.
- in_last  in  1  final beat of the matrix; driven by converter buffer_done, sampled with in_valid.
- core_data  out  WIDTH*CHUNK_SIZE*NUM_CORES_H  head FIFO entry; lane k = [k*WIDTH*CHUNK_SIZE +: WIDTH*CHUNK_SIZE].
- core_valid  out  NUM_CORES_H  per-lane valid.
- core_ready  in  NUM_CORES_H  per-lane ready from the cores.
- core_last  out  NUM_CORES_H  per-lane last; equals head.last AND core_valid[k].
- fifo_count  out  $clog2(DEPTH+1)  number of occupied entries.
- overflow  out  1  sticky; set when a beat is dropped.
- done  out  1  one-cycle pulse after the last-tagged entry fully retires.

Behaviour:
- Reset (async, rst=1): FIFO emptied, pointers and taken[] cleared. All outputs are 0: core_data, core_valid, core_last, fifo_count, overflow, done. Outputs stay 0 until the first push after rst deasserts.
- Storage: DEPTH entries of {last, data}. Write and read pointers wrap from DEPTH-1 to 0. core_data is read combinationally from the head entry.
- Push: on a clk edge where en=1 and in_valid=1, and either the FIFO is not full or a pop occurs in the same cycle, {in_last, in_data} is written at the write pointer.
- Latency: with the FIFO empty, a beat sampled at edge N drives core_valid high after edge N. There is no combinational in-to-out path.
- Lane handshake: core_valid[k] = en & !empty & !taken[k]. Lane k is accepted on an edge where core_valid[k] & core_ready[k]; taken[k] is then set.
- Pop: on the edge where every lane is either already taken or accepted in that cycle, the head is popped and taken[] is cleared to 0. Lanes may accept in any order and across any number of cycles. A lane never sees the same entry twice, and the next entry is not shown until all lanes have taken the current one.
- Simultaneous push and pop: fifo_count is unchanged. This is legal even when the FIFO is full; no overflow results.
- Overflow: push requested while full with no pop in that cycle. The beat is discarded, overflow is set and held until rst, and fifo_count is unchanged.
- en=0: no push, no pop, all core_valid forced 0, taken[] held. in_valid is ignored and does not set overflow.
- done: registered. High for exactly one cycle after the edge that pops an entry with last=1. Entries pushed after that one are unaffected.
- Reset mid-operation: buffered entries and partial taken[] state are discarded immediately (asynchronously). No lane re-presents the discarded data.
- FRAC_WIDTH is carried for interface consistency only; data bits pass through unchanged.

Test Plan:
1. Single beat, core_ready=3'b111, lane words 0x0100,0x0200,...,0x0C00 (Q8.8 values 1.0 to 12.0) → core_valid=3'b111 for exactly one cycle, one edge after capture. core_data matches in_data bit-exact. fifo_count goes 1 then 0.
2. Staggered ready: core_ready = 001, then 010, then 100 on successive cycles → core_valid goes 111, 110, 100, 000. fifo_count stays 1 until the third accept, then 0.
3. DEPTH=4, core_ready=0, five consecutive beats → fifo_count=4 and overflow=1 after the fifth. Drain with ready=111 yields beats 1-4 in order; beat 5 never appears.
4. FIFO full, core_ready=111, in_valid=1 → one push and one pop per cycle, fifo_count stays 4, overflow stays 0.
5. Three beats with in_last=1 on the third → core_last=111 only while the third beat is at the head. done pulses exactly once, one cycle after that beat pops.
6. Three entries buffered with taken=010, then rst pulsed → all outputs 0 immediately (asynchronously). After release, core_valid=0 until a new beat arrives; the new beat is presented on all three lanes.

Source files
------------

// File: rtl/r2b_core_dispatch.sv
// Buffers block beats from the horizontal row-to-block converter and fans each one
// out to NUM_CORES_H MAC core lanes, each with its own valid/ready handshake.
module r2b_core_dispatch #(
   parameter int WIDTH       = 16,
   parameter int FRAC_WIDTH  = 8,
   parameter int CHUNK_SIZE  = 4,
   parameter int NUM_CORES_H = 3,
   parameter int DEPTH       = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      en,
   input  logic                                      in_valid,
   input  logic [WIDTH*CHUNK_SIZE*NUM_CORES_H-1:0]   in_data,
   input  logic                                      in_last,
   output logic [WIDTH*CHUNK_SIZE*NUM_CORES_H-1:0]   core_data,
   output logic [NUM_CORES_H-1:0]                    core_valid,
   input  logic [NUM_CORES_H-1:0]                    core_ready,
   output logic [NUM_CORES_H-1:0]                    core_last,
   output logic [$clog2(DEPTH+1)-1:0]                fifo_count,
   output logic                                      overflow,
   output logic                                      done
);

   localparam int LANE_W = WIDTH * CHUNK_SIZE;
   localparam int DATA_W = LANE_W * NUM_CORES_H;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   // Data is never interpreted, so the only constraint on the Q format is that it fits.
   generate
      if (FRAC_WIDTH > WIDTH || DEPTH < 2) begin : g_param_err
         $error("r2b_core_dispatch: invalid FRAC_WIDTH or DEPTH");
      end
   endgenerate

   logic [DATA_W-1:0]      mem_data_r [DEPTH];
   logic [DEPTH-1:0]       mem_last_r;
   logic [PTR_W-1:0]       wr_ptr_r;
   logic [PTR_W-1:0]       rd_ptr_r;
   logic [CNT_W-1:0]       count_r;
   logic [NUM_CORES_H-1:0] taken_r;
   logic                   overflow_r;
   logic                   done_r;

   logic                   empty_s;
   logic                   full_s;
   logic                   active_s;
   logic [NUM_CORES_H-1:0] valid_s;
   logic [NUM_CORES_H-1:0] accept_s;
   logic                   pop_s;
   logic                   push_req_s;
   logic                   push_s;
   logic                   head_last_s;
   logic [DATA_W-1:0]      head_data_s;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Handshake, pop/push decisions and head-of-queue view.
   always_comb begin
      empty_s     = (count_r == CNT_W'(0));
      full_s      = (count_r == CNT_W'(DEPTH));
      active_s    = en & ~empty_s;
      valid_s     = {NUM_CORES_H{active_s}} & ~taken_r;
      accept_s    = valid_s & core_ready;
      // Head retires once every lane has it, whether taken earlier or this cycle.
      pop_s       = active_s & (&(taken_r | accept_s));
      push_req_s  = en & in_valid;
      push_s      = push_req_s & (~full_s | pop_s);
      head_last_s = mem_last_r[rd_ptr_r];
      if (empty_s) begin
         head_data_s = {DATA_W{1'b0}};
      end else begin
         head_data_s = mem_data_r[rd_ptr_r];
      end
   end

   // Entry storage; contents are qualified by count_r so they need no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_data_r[wr_ptr_r] <= in_data;
         mem_last_r[wr_ptr_r] <= in_last;
      end
   end

   // Pointers, occupancy, per-lane taken flags and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         taken_r    <= {NUM_CORES_H{1'b0}};
         overflow_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ptr_next(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
            taken_r  <= {NUM_CORES_H{1'b0}};
         end else begin
            taken_r  <= taken_r | accept_s;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         if (push_req_s & full_s & ~pop_s) begin
            overflow_r <= 1'b1;
         end
         done_r <= pop_s & head_last_s;
      end
   end

   assign core_data  = head_data_s;
   assign core_valid = valid_s;
   assign core_last  = valid_s & {NUM_CORES_H{head_last_s}};
   assign fifo_count = count_r;
   assign overflow   = overflow_r;
   assign done       = done_r;

endmodule

// File: tb/tb_r2b_core_dispatch.sv
// Directed, table-driven bench for r2b_core_dispatch with a hand-written async reset sequence.
module tb_r2b_core_dispatch;

   localparam int DW = 192;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic [DW-1:0] core_data;
   logic [2:0]    core_valid;
   logic [2:0]    core_ready = 3'b000;
   logic [2:0]    core_last;
   logic [2:0]    fifo_count;
   logic          overflow;
   logic          done;

   int checks = 0;
   int errors = 0;

   r2b_core_dispatch dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .core_data(core_data), .core_valid(core_valid),
      .core_ready(core_ready), .core_last(core_last), .fifo_count(fifo_count),
      .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en, vld, last;
      int         b;
      logic [2:0] rdy;
      logic [2:0] cv, cl;
      int         cnt;
      logic       ovf, dn;
      int         eb;
   } vec_t;

   vec_t vq[$];

   // Beat b, word i = b*0x1000 + (i+1)*0x0100; beat 0 is the Q8.8 sequence 1.0..12.0.
   function automatic logic [DW-1:0] beat(input int b);
      logic [DW-1:0] r;
      r = '0;
      if (b >= 0) begin
         for (int i = 0; i < 12; i++) r[i*16 +: 16] = 16'(b * 4096 + (i + 1) * 256);
      end
      return r;
   endfunction

   function automatic vec_t mk(input logic e, input logic v, input int b, input logic l,
                               input logic [2:0] rd, input logic [2:0] cv, input logic [2:0] cl,
                               input int cnt, input logic ovf, input logic dn, input int eb);
      vec_t t;
      t.en = e; t.vld = v; t.b = b; t.last = l; t.rdy = rd;
      t.cv = cv; t.cl = cl; t.cnt = cnt; t.ovf = ovf; t.dn = dn; t.eb = eb;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " core_data"}, core_data, '0);
      chk({tag, " core_valid"}, DW'(core_valid), '0);
      chk({tag, " core_last"}, DW'(core_last), '0);
      chk({tag, " fifo_count"}, DW'(fifo_count), '0);
      chk({tag, " overflow"}, DW'(overflow), '0);
      chk({tag, " done"}, DW'(done), '0);
   endtask

   initial begin
      //            en   vld  b   last rdy     cv      cl      cnt ovf  dn   eb
      // single beat, all lanes ready
      vq.push_back(mk(1'b1,1'b1, 0,1'b0,3'b111, 3'b000,3'b000, 0,1'b0,1'b0,-1));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 1,1'b0,1'b0, 0));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b000,3'b000, 0,1'b0,1'b0,-1));
      // staggered ready
      vq.push_back(mk(1'b1,1'b1, 1,1'b0,3'b000, 3'b000,3'b000, 0,1'b0,1'b0,-1));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b001, 3'b111,3'b000, 1,1'b0,1'b0, 1));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b010, 3'b110,3'b000, 1,1'b0,1'b0, 1));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b100, 3'b100,3'b000, 1,1'b0,1'b0, 1));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b000, 3'b000,3'b000, 0,1'b0,1'b0,-1));
      // fill to full, then push+pop while full
      vq.push_back(mk(1'b1,1'b1, 2,1'b0,3'b000, 3'b000,3'b000, 0,1'b0,1'b0,-1));
      vq.push_back(mk(1'b1,1'b1, 3,1'b0,3'b000, 3'b111,3'b000, 1,1'b0,1'b0, 2));
      vq.push_back(mk(1'b1,1'b1, 4,1'b0,3'b000, 3'b111,3'b000, 2,1'b0,1'b0, 2));
      vq.push_back(mk(1'b1,1'b1, 5,1'b0,3'b000, 3'b111,3'b000, 3,1'b0,1'b0, 2));
      vq.push_back(mk(1'b1,1'b1, 6,1'b0,3'b111, 3'b111,3'b000, 4,1'b0,1'b0, 2));
      vq.push_back(mk(1'b1,1'b1, 7,1'b0,3'b111, 3'b111,3'b000, 4,1'b0,1'b0, 3));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 4,1'b0,1'b0, 4));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 3,1'b0,1'b0, 5));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 2,1'b0,1'b0, 6));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 1,1'b0,1'b0, 7));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b000, 3'b000,3'b000, 0,1'b0,1'b0,-1));
      // five beats into four entries: fifth dropped, overflow sticky
      vq.push_back(mk(1'b1,1'b1, 8,1'b0,3'b000, 3'b000,3'b000, 0,1'b0,1'b0,-1));
      vq.push_back(mk(1'b1,1'b1, 9,1'b0,3'b000, 3'b111,3'b000, 1,1'b0,1'b0, 8));
      vq.push_back(mk(1'b1,1'b1,10,1'b0,3'b000, 3'b111,3'b000, 2,1'b0,1'b0, 8));
      vq.push_back(mk(1'b1,1'b1,11,1'b0,3'b000, 3'b111,3'b000, 3,1'b0,1'b0, 8));
      vq.push_back(mk(1'b1,1'b1,12,1'b0,3'b000, 3'b111,3'b000, 4,1'b0,1'b0, 8));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 4,1'b1,1'b0, 8));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 3,1'b1,1'b0, 9));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 2,1'b1,1'b0,10));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 1,1'b1,1'b0,11));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b000, 3'b000,3'b000, 0,1'b1,1'b0,-1));
      // last-tagged third beat: core_last and done
      vq.push_back(mk(1'b1,1'b1,13,1'b0,3'b000, 3'b000,3'b000, 0,1'b1,1'b0,-1));
      vq.push_back(mk(1'b1,1'b1,14,1'b0,3'b000, 3'b111,3'b000, 1,1'b1,1'b0,13));
      vq.push_back(mk(1'b1,1'b1,15,1'b1,3'b000, 3'b111,3'b000, 2,1'b1,1'b0,13));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 3,1'b1,1'b0,13));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b000, 2,1'b1,1'b0,14));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b111, 3'b111,3'b111, 1,1'b1,1'b0,15));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b000, 3'b000,3'b000, 0,1'b1,1'b1,-1));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b000, 3'b000,3'b000, 0,1'b1,1'b0,-1));
      // en=0 ignores in_valid, masks valid and holds taken
      vq.push_back(mk(1'b0,1'b1, 1,1'b0,3'b111, 3'b000,3'b000, 0,1'b1,1'b0,-1));
      vq.push_back(mk(1'b1,1'b1, 2,1'b0,3'b000, 3'b000,3'b000, 0,1'b1,1'b0,-1));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b010, 3'b111,3'b000, 1,1'b1,1'b0, 2));
      vq.push_back(mk(1'b0,1'b1, 3,1'b0,3'b111, 3'b000,3'b000, 1,1'b1,1'b0, 2));
      vq.push_back(mk(1'b1,1'b0, 0,1'b0,3'b000, 3'b101,3'b000, 1,1'b1,1'b0, 2));
      // build three entries with taken=010 ahead of the reset sequence
      vq.push_back(mk(1'b1,1'b1, 4,1'b0,3'b000, 3'b101,3'b000, 1,1'b1,1'b0, 2));
      vq.push_back(mk(1'b1,1'b1, 5,1'b0,3'b000, 3'b101,3'b000, 2,1'b1,1'b0, 2));

      // reset state
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      for (int r = 0; r < vq.size(); r++) begin
         string tag;
         vec_t  v;
         v = vq[r];
         tag = $sformatf("row%0d", r);
         @(negedge clk);
         en = v.en; in_valid = v.vld; in_data = beat(v.b); in_last = v.last; core_ready = v.rdy;
         #1;
         chk({tag, " core_valid"}, DW'(core_valid), DW'(v.cv));
         chk({tag, " core_last"},  DW'(core_last),  DW'(v.cl));
         chk({tag, " fifo_count"}, DW'(fifo_count), DW'(v.cnt));
         chk({tag, " overflow"},   DW'(overflow),   DW'(v.ovf));
         chk({tag, " done"},       DW'(done),       DW'(v.dn));
         chk({tag, " core_data"},  core_data,       beat(v.eb));
      end

      // mid-operation async reset with three entries and taken=010
      @(negedge clk);
      in_valid = 1'b0; core_ready = 3'b000;
      #1;
      chk("pre_rst fifo_count", DW'(fifo_count), DW'(3));
      chk("pre_rst core_valid", DW'(core_valid), DW'(3'b101));
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      rst = 1'b0; core_ready = 3'b111;
      repeat (2) begin
         @(negedge clk);
         #1;
         chk_zero("post_rst idle");
      end
      in_valid = 1'b1; in_data = beat(9); in_last = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("post_rst core_valid", DW'(core_valid), DW'(3'b111));
      chk("post_rst core_data", core_data, beat(9));
      chk("post_rst fifo_count", DW'(fifo_count), DW'(1));
      @(negedge clk);
      #1;
      chk("post_rst drained", DW'(fifo_count), DW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
